// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave over a single-port, byte-writable SRAM array.
// AW/W/AR are buffered in holding registers; reads and writes share the array through a fair arbiter.
module axi_lite_sram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    i_w_aclk,
  input  logic                    i_w_areset,
  input  logic                    i_w_awvalid,
  output logic                    o_w_awready,
  input  logic [ADDR_WIDTH-1:0]   i_w_awaddr,
  input  logic                    i_w_wvalid,
  output logic                    o_w_wready,
  input  logic [DATA_WIDTH-1:0]   i_w_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_w_wstrb,
  output logic                    o_w_bvalid,
  input  logic                    i_w_bready,
  output logic [1:0]              o_w_bresp,
  input  logic                    i_w_arvalid,
  output logic                    o_w_arready,
  input  logic [ADDR_WIDTH-1:0]   i_w_araddr,
  output logic                    o_w_rvalid,
  input  logic                    i_w_rready,
  output logic [1:0]              o_w_rresp,
  output logic [DATA_WIDTH-1:0]   o_w_rdata
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_held_q, w_held_q, ar_held_q;
  logic [DEPTH_LOG2-1:0] aw_idx_q, ar_idx_q;
  logic                  aw_oor_q, ar_oor_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_prio_q;
  logic                  wr_pend, rd_pend, wr_gnt, rd_gnt;
  logic                  unused_addr_lsbs;

  function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + DEPTH_LOG2)) != '0;
  endfunction

  // Sub-word address bits are ignored: accesses are treated as aligned.
  assign unused_addr_lsbs = ^{i_w_awaddr[ADDR_LSB-1:0], i_w_araddr[ADDR_LSB-1:0]};

  assign o_w_awready = !aw_held_q && !i_w_areset;
  assign o_w_wready  = !w_held_q && !i_w_areset;
  assign o_w_arready = !ar_held_q && !rvalid_q && !i_w_areset;
  assign o_w_bvalid  = bvalid_q;
  assign o_w_bresp   = bresp_q;
  assign o_w_rvalid  = rvalid_q;
  assign o_w_rresp   = rresp_q;
  assign o_w_rdata   = rdata_q;

  // rd_prio_q flips only on real contention, so a lone grant does not steal the next tie.
  always_comb begin
    wr_pend = aw_held_q && w_held_q && !bvalid_q;
    rd_pend = ar_held_q && !rvalid_q;
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    if (wr_pend && rd_pend) begin
      rd_gnt = rd_prio_q;
      wr_gnt = !rd_prio_q;
    end else begin
      wr_gnt = wr_pend;
      rd_gnt = rd_pend;
    end
  end

  always_ff @(posedge i_w_aclk or posedge i_w_areset) begin
    if (i_w_areset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_idx_q  <= '0;
      ar_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      ar_oor_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_prio_q <= 1'b1;
    end else begin
      if (i_w_awvalid && o_w_awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= i_w_awaddr[ADDR_LSB +: DEPTH_LOG2];
        aw_oor_q  <= is_oor(i_w_awaddr);
      end
      if (i_w_wvalid && o_w_wready) begin
        w_held_q <= 1'b1;
        w_data_q <= i_w_wdata;
        w_strb_q <= i_w_wstrb;
      end
      if (i_w_arvalid && o_w_arready) begin
        ar_held_q <= 1'b1;
        ar_idx_q  <= i_w_araddr[ADDR_LSB +: DEPTH_LOG2];
        ar_oor_q  <= is_oor(i_w_araddr);
      end

      if (wr_gnt) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && i_w_bready) begin
        bvalid_q <= 1'b0;
      end

      if (rd_gnt) begin
        ar_held_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rresp_q   <= ar_oor_q ? RESP_SLVERR : RESP_OKAY;
        rdata_q   <= ar_oor_q ? '0 : mem[ar_idx_q];
      end else if (rvalid_q && i_w_rready) begin
        rvalid_q <= 1'b0;
      end

      if (wr_pend && rd_pend) rd_prio_q <= !rd_prio_q;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge i_w_aclk) begin
    if (wr_gnt && !aw_oor_q) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_axi_lite_sram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl [1024];
  bit          rd_wins = 1'b1;

  always #5 clk = ~clk;

  axi_lite_sram dut (
    .i_w_aclk(clk), .i_w_areset(rst),
    .i_w_awvalid(awvalid), .o_w_awready(awready), .i_w_awaddr(awaddr),
    .i_w_wvalid(wvalid), .o_w_wready(wready), .i_w_wdata(wdata), .i_w_wstrb(wstrb),
    .o_w_bvalid(bvalid), .i_w_bready(bready), .o_w_bresp(bresp),
    .i_w_arvalid(arvalid), .o_w_arready(arready), .i_w_araddr(araddr),
    .o_w_rvalid(rvalid), .i_w_rready(rready), .o_w_rresp(rresp), .o_w_rdata(rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: 1024-word array, 4 KiB address space, anything above is an error.
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a >= 32'h1000) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (a >= 32'h1000) return 32'h0;
    return mdl[a[11:2]];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (a < 32'h1000) begin
      w = mdl[a[11:2]];
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[a[11:2]] = w;
    end
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_acc, w_acc;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == aw_dly) begin awvalid = 1'b1; awaddr = a; end
      if (cyc == w_dly)  begin wvalid = 1'b1; wdata = d; wstrb = s; end
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick;
      cyc++;
      if (aw_acc) begin awvalid = 1'b0; aw_done = 1; end
      if (w_acc)  begin wvalid = 1'b0; w_done = 1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
  endtask

  task automatic issue_rd(input logic [31:0] a);
    bit done = 0, acc;
    int cyc = 0;
    arvalid = 1'b1;
    araddr  = a;
    while (!done && cyc < 40) begin
      acc = arready;
      tick;
      cyc++;
      if (acc) done = 1;
    end
    arvalid = 1'b0;
    check("ar_accept", done, 1);
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp, output int lat);
    lat = 0;
    while (!bvalid && lat < 20) begin tick; lat++; end
    check("b_seen", bvalid, 1);
    resp = bresp;
    for (int h = 0; h < hold; h++) begin
      tick;
      check("b_hold", {bvalid, bresp}, {1'b1, resp});
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    check("b_drop", bvalid, 0);
  endtask

  task automatic wait_r(input int hold, output logic [31:0] d, output logic [1:0] resp,
                        output int lat);
    lat = 0;
    while (!rvalid && lat < 20) begin tick; lat++; end
    check("r_seen", rvalid, 1);
    d    = rdata;
    resp = rresp;
    for (int h = 0; h < hold; h++) begin
      tick;
      check("r_hold", {rvalid, rresp, rdata}, {1'b1, resp, d});
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    check("r_drop_arready", {rvalid, arready}, 2'b01);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int hold, output int lat);
    logic [1:0] r;
    issue_wr(a, d, s, aw_dly, w_dly);
    wait_b(hold, r, lat);
    check("wr_resp", r, exp_resp(a));
    mdl_write(a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input int hold, output int lat);
    logic [31:0] d;
    logic [1:0]  r;
    issue_rd(a);
    wait_r(hold, d, r, lat);
    check("rd_data", d, mdl_read(a));
    check("rd_resp", r, exp_resp(a));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  // Both sides request the same word in the same cycle; the bench tracks who should win.
  task automatic contend(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] old_v, rd_d;
    logic [1:0]  wr_r, rd_r;
    int          lw, lr;
    old_v = mdl_read(a);
    fork
      begin issue_wr(a, d, 4'hF, 0, 0); wait_b(0, wr_r, lw); end
      begin issue_rd(a); wait_r(0, rd_d, rd_r, lr); end
    join
    check("cont_rd_lat", lr, rd_wins ? 1 : 2);
    check("cont_wr_lat", lw, rd_wins ? 2 : 1);
    check("cont_rd_data", rd_d, rd_wins ? old_v : d);
    check("cont_resps", {wr_r, rd_r}, 4'b0000);
    mdl_write(a, d, 4'hF);
    rd_wins = !rd_wins;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] a, d;

    #3;
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_outputs", {bvalid, rvalid, bresp, rresp, rdata}, 38'h0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Basic write then read
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, lat);
    check("basic_wr_lat", lat, 1);
    rd(32'h10, 0, lat);
    check("basic_rd_lat", lat, 1);

    // Byte strobes with W leading AW by 3 cycles
    wr(32'h20, 32'h11223344, 4'hF, 0, 0, 0, lat);
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 3, 0, 0, lat);
    check("skew_wr_lat", lat, 1);
    check("strobe_model", mdl_read(32'h20), 32'h11BB33DD);
    rd(32'h20, 1, lat);

    // Out of range
    wr(32'h0, 32'h01020304, 4'hF, 0, 0, 0, lat);
    wr(32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 0, lat);
    rd(32'h1000, 0, lat);
    rd(32'h0, 0, lat);

    // Contention fairness right after reset (array contents survive reset)
    wr(32'h40, 32'h0BADC0DE, 4'hF, 0, 0, 0, lat);
    do_reset();
    rd_wins = 1'b1;
    contend(32'h40, 32'h12345678);
    contend(32'h40, 32'h87654321);
    rd(32'h40, 0, lat);

    // Backpressure on B with a second write queued behind it
    bready = 1'b0;
    issue_wr(32'h80, 32'h5555AAAA, 4'hF, 0, 0);
    tick;
    check("bp_first_b", {bvalid, bresp}, 3'b100);
    issue_wr(32'h84, 32'h13579BDF, 4'hF, 0, 0);
    check("bp_second_latched", {awready, wready}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bvalid, bresp}, 3'b100);
      tick;
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    check("bp_after_hs", bvalid, 0);
    tick;
    check("bp_second_b", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    mdl_write(32'h80, 32'h5555AAAA, 4'hF);
    mdl_write(32'h84, 32'h13579BDF, 4'hF);
    rd(32'h84, 0, lat);
    rd(32'h80, 0, lat);

    // Asynchronous reset while a read response is pending
    issue_rd(32'h10);
    tick;
    check("ar_rst_pre", rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rst_rvalid", rvalid, 0);
    check("ar_rst_readies", {awready, wready, arready}, 3'b000);
    check("ar_rst_outputs", {bvalid, bresp, rresp, rdata}, 37'h0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("ar_rst_release", {awready, wready, arready}, 3'b111);

    // Randomized traffic over a 16-word window with occasional out-of-range addresses
    for (int w = 0; w < 16; w++) wr(w * 4, $urandom, 4'hF, 0, 0, 0, lat);
    for (int n = 0; n < 150; n++) begin
      a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2), lat);
        check("rand_wr_lat", lat, 1);
      end else begin
        rd(a, $urandom_range(0, 2), lat);
        check("rand_rd_lat", lat, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
